// File: rtl/sb_node_route_sequencer.sv
// Node/route sequencer for a line-following robot: debounces the three line
// sensors, follows the line between nodes and executes a stored action per node.
module sb_node_route_sequencer #(
    parameter int ADDR_W          = 4,
    parameter int ROUTE_DEPTH     = 2 ** ADDR_W,
    parameter int DEBOUNCE        = 4,
    parameter int CROSS_CYCLES    = 1000,
    parameter int TURN_MIN_CYCLES = 500
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              start,
    input  logic              sensor_1,
    input  logic              sensor_2,
    input  logic              sensor_3,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data,
    output logic [2:0]        turn,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] node_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_CROSS  = 3'd2,
        S_TURN   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] ACT_STRAIGHT = 2'b00;
    localparam logic [1:0] ACT_LEFT     = 2'b01;
    localparam logic [1:0] ACT_END      = 2'b11;

    localparam logic [2:0] CMD_STOP   = 3'b000;
    localparam logic [2:0] CMD_FWD    = 3'b001;
    localparam logic [2:0] CMD_LEFT   = 3'b010;
    localparam logic [2:0] CMD_RIGHT  = 3'b011;
    localparam logic [2:0] CMD_SEARCH = 3'b100;

    localparam logic [2:0] PAT_CENTRE = 3'b010;
    localparam logic [2:0] PAT_NODE   = 3'b111;

    localparam int DB_W    = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int CNT_MAX = (CROSS_CYCLES > TURN_MIN_CYCLES) ? CROSS_CYCLES : TURN_MIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  CROSS_LAST = CNT_W'(CROSS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TURN_MIN   = CNT_W'(TURN_MIN_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(CNT_MAX);
    localparam logic [ADDR_W-1:0] IDX_LAST   = ADDR_W'(ROUTE_DEPTH - 1);

    function automatic logic [2:0] follow_map(input logic [2:0] pat);
        logic [2:0] cmd;
        case (pat)
            3'b010:         cmd = CMD_FWD;
            3'b110, 3'b100: cmd = CMD_LEFT;
            3'b011, 3'b001: cmd = CMD_RIGHT;
            3'b000, 3'b101: cmd = CMD_SEARCH;
            3'b111:         cmd = CMD_FWD;
            default:        cmd = CMD_STOP;
        endcase
        return cmd;
    endfunction

    logic [2:0]        raw_s;
    logic [2:0]        raw_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic [2:0]        f_q;
    logic [2:0]        f_prev_q;
    logic              node_ev_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] node_idx_q, node_idx_d;
    logic [1:0]        action_q, action_d;
    logic              all_q, all_d;
    logic [2:0]        turn_q, turn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        entry_s;
    logic              wr_ok_s;

    logic [1:0]        route_q [ROUTE_DEPTH];

    assign raw_s     = {sensor_1, sensor_2, sensor_3};
    assign node_ev_s = (f_q == PAT_NODE) && (f_prev_q != PAT_NODE);
    assign entry_s   = route_q[node_idx_q];
    assign wr_ok_s   = !reset && wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Debounce: f follows the raw pattern once it has been stable for DEBOUNCE samples.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            raw_q    <= PAT_CENTRE;
            db_cnt_q <= {DB_W{1'b0}};
            f_q      <= PAT_CENTRE;
            f_prev_q <= PAT_CENTRE;
        end else begin
            raw_q    <= raw_s;
            f_prev_q <= f_q;
            if (raw_s != raw_q) begin
                db_cnt_q <= {DB_W{1'b0}};
            end else if (db_cnt_q != DB_LAST) begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end else begin
                f_q <= raw_s;
            end
        end
    end

    // Route memory keeps its contents across reset.
    always_ff @(posedge clk_50) begin
        if (wr_ok_s) begin
            route_q[wr_addr] <= wr_data;
        end
    end

    // State, datapath and registered output update.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            node_idx_q <= {ADDR_W{1'b0}};
            action_q   <= ACT_STRAIGHT;
            all_q      <= 1'b0;
            turn_q     <= CMD_STOP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            node_idx_q <= node_idx_d;
            action_q   <= action_d;
            all_q      <= all_d;
            turn_q     <= turn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state: node handling, crossing timer and turn completion.
    always_comb begin
        state_d    = state_q;
        node_idx_d = node_idx_q;
        action_d   = action_q;
        all_d      = all_q;
        cnt_d      = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FOLLOW;
                    node_idx_d = {ADDR_W{1'b0}};
                    all_d      = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_FOLLOW: begin
                if (node_ev_s) begin
                    if (all_q || (entry_s == ACT_END)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_CROSS;
                        action_d = entry_s;
                        cnt_d    = {CNT_W{1'b0}};
                    end
                end else begin
                    state_d = S_FOLLOW;
                end
            end
            S_CROSS: begin
                if (cnt_q != CROSS_LAST) begin
                    state_d = S_CROSS;
                end else if (action_q == ACT_STRAIGHT) begin
                    state_d    = S_FOLLOW;
                    node_idx_d = node_idx_q + ADDR_W'(1);
                    all_d      = (node_idx_q == IDX_LAST) ? 1'b1 : all_q;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            S_TURN: begin
                if ((cnt_q >= TURN_MIN) && (f_q == PAT_CENTRE)) begin
                    state_d    = S_FOLLOW;
                    node_idx_d = node_idx_q + ADDR_W'(1);
                    all_d      = (node_idx_q == IDX_LAST) ? 1'b1 : all_q;
                end else begin
                    state_d = S_TURN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the state being entered, so they register alongside it.
    always_comb begin
        turn_d = CMD_STOP;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            S_IDLE: begin
                turn_d = CMD_STOP;
            end
            S_FOLLOW: begin
                turn_d = follow_map(f_q);
                busy_d = 1'b1;
            end
            S_CROSS: begin
                turn_d = CMD_FWD;
                busy_d = 1'b1;
            end
            S_TURN: begin
                turn_d = (action_d == ACT_LEFT) ? CMD_LEFT : CMD_RIGHT;
                busy_d = 1'b1;
            end
            S_DONE: begin
                turn_d = CMD_STOP;
                done_d = 1'b1;
            end
            default: begin
                turn_d = CMD_STOP;
            end
        endcase
    end

    assign turn     = turn_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign node_idx = node_idx_q;

endmodule
